// File: rtl/esp_req_sequencer.sv
// Request sequencer for the TRS-IO -> ESP co-processor path.
// Latches the request code on a qualified I/O strobe, holds the Z80 in WAIT,
// drives a fixed-width ESP_REQ pulse and releases WAIT on the ESP's done edge
// or when the watchdog expires.
module esp_req_sequencer #(
    parameter int unsigned REQ_PULSE_CYCLES = 50,
    parameter int unsigned TIMEOUT_CYCLES   = 840000,
    parameter int unsigned TO_WIDTH         = 20
) (
    input  logic       clk,
    input  logic       RST_N,
    input  logic       sel,
    input  logic       strobe,
    input  logic [2:0] kind,
    input  logic       ESP_DONE,
    input  logic       err_clr,
    output logic       ESP_REQ,
    output logic [2:0] ESP_S,
    output logic       WAIT,
    output logic       busy,
    output logic       timeout_err,
    output logic [7:0] timeout_cnt
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_REQ       = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_RELEASE   = 2'd3;

    localparam int unsigned       PW         = $clog2(REQ_PULSE_CYCLES + 1);
    localparam logic [PW-1:0]     PULSE_LOAD = PW'(REQ_PULSE_CYCLES);
    localparam logic [PW-1:0]     PULSE_ONE  = PW'(1);
    localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_WIDTH-1:0] TO_ONE   = TO_WIDTH'(1);

    logic [1:0]          state_q, state_d;
    logic [PW-1:0]       pulse_q, pulse_d;
    logic [TO_WIDTH-1:0] wd_q, wd_d;
    logic                req_q, req_d;
    logic                wait_q, wait_d;
    logic [2:0]          kind_q, kind_d;
    logic                seen_q, seen_d;
    logic                err_q, err_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic [2:0]          done_sync_q;
    logic                done_edge;

    // [0],[1] form the synchronizer, [2] is the edge-detect register.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            done_sync_q <= 3'b000;
        end else begin
            done_sync_q <= {done_sync_q[1:0], ESP_DONE};
        end
    end

    assign done_edge = done_sync_q[1] & ~done_sync_q[2];

    // Next-state and registered-output logic for the request FSM.
    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        wd_d    = wd_q;
        req_d   = req_q;
        wait_d  = wait_q;
        kind_d  = kind_q;
        seen_d  = seen_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        // A timeout raised below in the same cycle overrides this clear.
        if (err_clr) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (strobe && sel) begin
                    kind_d  = kind;
                    req_d   = 1'b1;
                    wait_d  = 1'b1;
                    pulse_d = PULSE_LOAD;
                    wd_d    = '0;
                    seen_d  = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                pulse_d = pulse_q - PULSE_ONE;
                wd_d    = wd_q + TO_ONE;
                if (done_edge) begin
                    wait_d = 1'b0;
                    seen_d = 1'b1;
                end
                if (pulse_q == PULSE_ONE) begin
                    req_d   = 1'b0;
                    state_d = (seen_q || done_edge) ? ST_RELEASE : ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                wd_d = wd_q + TO_ONE;
                // Done has priority over a simultaneous watchdog expiry.
                if (done_edge) begin
                    wait_d  = 1'b0;
                    state_d = ST_RELEASE;
                end else if (wd_q == TO_LAST) begin
                    wait_d  = 1'b0;
                    err_d   = 1'b1;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Hold until the Z80 leaves this bus cycle so it cannot re-trigger.
                if (!sel) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_d = (state_d != ST_IDLE);

    // State and output registers; reset clears everything mid-request too.
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            pulse_q <= '0;
            wd_q    <= '0;
            req_q   <= 1'b0;
            wait_q  <= 1'b0;
            kind_q  <= 3'd0;
            seen_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            wd_q    <= wd_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
            kind_q  <= kind_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign ESP_REQ     = req_q;
    assign ESP_S       = kind_q;
    assign WAIT        = wait_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;
    assign timeout_cnt = cnt_q;

endmodule
